// File: rtl/ip_sequencer.sv
// Fetch sequencer for an external increment/load IP register. It issues one fetch per
// instruction, then one update cycle (advance or redirect) that uses an internal return stack.
module ip_sequencer #(
    parameter int AW          = 16,
    parameter int STACK_DEPTH = 4,
    parameter int MAX_WAIT    = 15
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          halt,
    input  logic [AW-1:0] ip_q,
    output logic          ip_ena,
    output logic          ip_sel,
    output logic [AW-1:0] ip_d,
    output logic          fetch_req,
    output logic [AW-1:0] fetch_addr,
    input  logic          fetch_ack,
    input  logic          br_valid,
    input  logic [1:0]    br_type,
    input  logic [AW-1:0] br_target,
    output logic          br_ready,
    output logic          busy,
    output logic          stk_ovf,
    output logic          stk_unf,
    output logic          err_timeout
);

    localparam int SPW = $clog2(STACK_DEPTH);
    localparam int WW  = $clog2(MAX_WAIT + 1);
    localparam logic [SPW:0]  SP_FULL   = (SPW+1)'(STACK_DEPTH);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, ADVANCE, REDIRECT, ERROR} state_t;

    state_t        state, state_nxt;
    logic [SPW:0]  sp;
    logic [SPW:0]  sp_m1;
    logic [AW-1:0] stack [STACK_DEPTH];
    logic [WW-1:0] wait_cnt;
    logic [1:0]    br_type_q;
    logic [AW-1:0] br_target_q;
    logic [AW-1:0] ip_inc;
    logic          acc_br, timeout, stk_full, stk_empty, is_call, is_ret;

    assign sp_m1     = sp - 1'b1;
    assign ip_inc    = ip_q + 1'b1;
    assign stk_full  = (sp == SP_FULL);
    assign stk_empty = (sp == '0);
    assign is_call   = (br_type_q == 2'b01);
    assign is_ret    = (br_type_q == 2'b10);
    assign acc_br    = (state == FETCH) && fetch_ack && br_valid;
    // The ack may still arrive in the MAX_WAIT-th waiting cycle; only a miss there times out.
    assign timeout   = (state == FETCH) && !fetch_ack && (wait_cnt == WAIT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            sp          <= '0;
            wait_cnt    <= '0;
            br_type_q   <= '0;
            br_target_q <= '0;
            stk_ovf     <= 1'b0;
            stk_unf     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FETCH)
                wait_cnt <= fetch_ack ? '0 : wait_cnt + 1'b1;
            if (timeout)
                err_timeout <= 1'b1;
            if (acc_br) begin
                br_type_q   <= br_type;
                br_target_q <= br_target;
            end
            if (state == REDIRECT) begin
                if (is_call) begin
                    if (stk_full) stk_ovf <= 1'b1;
                    else          sp      <= sp + 1'b1;
                end else if (is_ret) begin
                    if (stk_empty) stk_unf <= 1'b1;
                    else           sp      <= sp_m1;
                end
            end
        end
    end

    // Stack contents need no reset; sp alone defines what is valid.
    always_ff @(posedge CLK) begin
        if (!RST && state == REDIRECT && is_call && !stk_full)
            stack[sp[SPW-1:0]] <= ip_inc;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start && !halt) state_nxt = FETCH;
            FETCH: begin
                if (fetch_ack)    state_nxt = br_valid ? REDIRECT : ADVANCE;
                else if (timeout) state_nxt = ERROR;
            end
            ADVANCE,
            REDIRECT: state_nxt = halt ? IDLE : FETCH;
            ERROR:    state_nxt = ERROR;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ip_ena     = 1'b0;
        ip_sel     = 1'b0;
        ip_d       = '0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        br_ready   = 1'b0;
        busy       = 1'b0;
        case (state)
            FETCH: begin
                busy       = 1'b1;
                fetch_req  = 1'b1;
                fetch_addr = ip_q;
                br_ready   = fetch_ack && br_valid;
            end
            ADVANCE: begin
                busy   = 1'b1;
                ip_ena = 1'b1;
            end
            REDIRECT: begin
                busy   = 1'b1;
                ip_ena = 1'b1;
                if (is_ret) begin
                    // An empty-stack return degrades to a plain increment.
                    if (!stk_empty) begin
                        ip_sel = 1'b1;
                        ip_d   = stack[sp_m1[SPW-1:0]];
                    end
                end else begin
                    ip_sel = 1'b1;
                    ip_d   = br_target_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ip_sequencer.sv
// Bench for ip_sequencer: models the IP register, and predicts each instruction from
// a transaction-level model (expected IP plus a queue used as the return stack).
module tb_ip_sequencer;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0, RST = 1'b1, start = 1'b0, halt = 1'b0;
    logic        fetch_ack = 1'b0, br_valid = 1'b0;
    logic [1:0]  br_type = 2'b00;
    logic [15:0] br_target = 16'h0;
    logic [15:0] ip = 16'h0;
    logic        tb_load = 1'b0;
    logic [15:0] tb_val = 16'h0;
    logic        ip_ena, ip_sel, fetch_req, br_ready, busy, stk_ovf, stk_unf, err_timeout;
    logic [15:0] ip_d, fetch_addr;

    int checks = 0, failures = 0;
    logic [15:0] m_ip;
    logic [15:0] m_stk [$];
    logic        m_ovf, m_unf;

    ip_sequencer #(.AW(16), .STACK_DEPTH(DEPTH), .MAX_WAIT(15)) dut (
        .CLK(CLK), .RST(RST), .start(start), .halt(halt), .ip_q(ip),
        .ip_ena(ip_ena), .ip_sel(ip_sel), .ip_d(ip_d),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .br_valid(br_valid), .br_type(br_type), .br_target(br_target), .br_ready(br_ready),
        .busy(busy), .stk_ovf(stk_ovf), .stk_unf(stk_unf), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    // The IP register itself (the sequencer only drives its ENA/SEL/D)
    always @(posedge CLK) begin
        if (tb_load)     ip <= tb_val;
        else if (ip_ena) ip <= ip_sel ? ip_d : ip + 16'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; start = 1'b0; halt = 1'b0; fetch_ack = 1'b0; br_valid = 1'b0;
        tick();
        RST = 1'b0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic load_ip(input logic [15:0] v);
        tb_load = 1'b1; tb_val = v;
        tick();
        tb_load = 1'b0;
        m_ip = v;
    endtask

    task automatic begin_run();
        start = 1'b1; halt = 1'b0; #1;
        checks++;
        if ({busy, fetch_req, ip_ena} !== 3'b000) begin
            failures++;
            $display("FAIL idle_outputs: busy=%b req=%b ena=%b, want 000", busy, fetch_req, ip_ena);
        end
        tick();
        start = 1'b0; #1;
        checks++;
        if ({busy, fetch_req, fetch_addr} !== {2'b11, m_ip}) begin
            failures++;
            $display("FAIL run_start: busy=%b req=%b addr=%h, want 1 1 %h", busy, fetch_req, fetch_addr, m_ip);
        end
    endtask

    // One instruction from a FETCH cycle through its update cycle, against the model.
    task automatic do_instr(input int dly, input logic brv, input logic [1:0] typ,
                            input logic [15:0] tgt, input logic h);
        logic        exp_sel;
        logic [15:0] exp_d, nxt;
        halt = h;
        for (int i = 0; i < dly; i++) begin
            fetch_ack = 1'b0; br_valid = brv; br_type = typ; br_target = tgt; #1;
            checks++;
            if ({fetch_req, fetch_addr, br_ready, ip_ena} !== {1'b1, m_ip, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL fetch_wait: req=%b addr=%h rdy=%b ena=%b, want 1 %h 0 0",
                         fetch_req, fetch_addr, br_ready, ip_ena, m_ip);
            end
            tick();
        end
        fetch_ack = 1'b1; br_valid = brv; br_type = typ; br_target = tgt; #1;
        checks++;
        if ({fetch_req, fetch_addr, br_ready, ip_ena} !== {1'b1, m_ip, brv, 1'b0}) begin
            failures++;
            $display("FAIL fetch_ack: req=%b addr=%h rdy=%b ena=%b, want 1 %h %b 0",
                     fetch_req, fetch_addr, br_ready, ip_ena, m_ip, brv);
        end
        tick();
        fetch_ack = 1'b0; br_valid = 1'b0; #1;
        exp_sel = 1'b0; exp_d = tgt; nxt = m_ip + 16'd1;
        if (brv) begin
            if (typ == 2'b10) begin
                if (m_stk.size() > 0) begin
                    exp_sel = 1'b1; exp_d = m_stk.pop_back(); nxt = exp_d;
                end else m_unf = 1'b1;
            end else begin
                exp_sel = 1'b1; exp_d = tgt; nxt = tgt;
                if (typ == 2'b01) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(m_ip + 16'd1);
                    else m_ovf = 1'b1;
                end
            end
        end
        checks++;
        if ({ip_ena, ip_sel, fetch_req, busy} !== {1'b1, exp_sel, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL update: ena=%b sel=%b req=%b busy=%b, want 1 %b 0 1",
                     ip_ena, ip_sel, fetch_req, busy, exp_sel);
        end
        if (exp_sel) begin
            checks++;
            if (ip_d !== exp_d) begin
                failures++;
                $display("FAIL update_d: ip_d=%h, want %h", ip_d, exp_d);
            end
        end
        m_ip = nxt;
        tick();
        checks++;
        if ({fetch_req, busy, ip_ena, fetch_addr, stk_ovf, stk_unf, err_timeout} !==
            {~h, ~h, 1'b0, (h ? 16'h0 : m_ip), m_ovf, m_unf, 1'b0}) begin
            failures++;
            $display("FAIL after_update: req=%b busy=%b ena=%b addr=%h ovf=%b unf=%b to=%b, want %b %b 0 %h %b %b 0",
                     fetch_req, busy, ip_ena, fetch_addr, stk_ovf, stk_unf, err_timeout,
                     ~h, ~h, (h ? 16'h0 : m_ip), m_ovf, m_unf);
        end
        halt = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(); #1;
        checks++;
        if ({ip_ena, ip_sel, ip_d, fetch_req, fetch_addr, br_ready, busy, stk_ovf, stk_unf, err_timeout} !== 39'b0) begin
            failures++;
            $display("FAIL reset_outputs: ena=%b sel=%b d=%h req=%b addr=%h rdy=%b busy=%b flags=%b%b%b, want all 0",
                     ip_ena, ip_sel, ip_d, fetch_req, fetch_addr, br_ready, busy, stk_ovf, stk_unf, err_timeout);
        end
        start = 1'b1; halt = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, fetch_req} !== 2'b00) begin
            failures++;
            $display("FAIL halt_wins: busy=%b req=%b, want 00", busy, fetch_req);
        end
        start = 1'b0; halt = 1'b0;
    endtask

    task automatic test_advance_jump();
        do_reset(); load_ip(16'h0000); begin_run();
        do_instr(0, 1'b0, 2'b00, 16'h0000, 1'b0);
        do_instr(0, 1'b1, 2'b00, 16'h1234, 1'b0);
        do_instr(3, 1'b1, 2'b11, 16'h4321, 1'b1);
    endtask

    task automatic test_call_ret();
        do_reset(); load_ip(16'h0010); begin_run();
        do_instr(0, 1'b1, 2'b01, 16'h0200, 1'b0);
        do_instr(2, 1'b0, 2'b00, 16'h0000, 1'b0);
        do_instr(0, 1'b1, 2'b10, 16'h0000, 1'b0);
        do_instr(0, 1'b1, 2'b10, 16'h0000, 1'b0);
    endtask

    task automatic test_overflow();
        do_reset(); load_ip(16'h0000); begin_run();
        for (int i = 0; i < 5; i++) do_instr(0, 1'b1, 2'b01, 16'h0100 + 16'(i * 16), 1'b0);
        checks++;
        if (stk_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag: stk_ovf=%b, want 1", stk_ovf);
        end
        for (int i = 0; i < 5; i++) do_instr(0, 1'b1, 2'b10, 16'h0000, 1'b0);
        checks++;
        if ({stk_ovf, stk_unf} !== 2'b11) begin
            failures++;
            $display("FAIL unf_flag: ovf=%b unf=%b, want 11", stk_ovf, stk_unf);
        end
    endtask

    task automatic test_timeout();
        do_reset(); load_ip(16'h0040); begin_run();
        do_instr(14, 1'b0, 2'b00, 16'h0000, 1'b0);
        fetch_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++;
            if (fetch_req !== 1'b1) begin
                failures++;
                $display("FAIL timeout_wait: cycle %0d req=%b, want 1", i, fetch_req);
            end
            tick();
        end
        start = 1'b1; fetch_ack = 1'b1; br_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({fetch_req, busy, err_timeout, ip_ena, br_ready} !== 5'b00100) begin
                failures++;
                $display("FAIL error_state: req=%b busy=%b to=%b ena=%b rdy=%b, want 0 0 1 0 0",
                         fetch_req, busy, err_timeout, ip_ena, br_ready);
            end
            tick();
        end
        do_reset(); #1;
        checks++;
        if ({fetch_req, busy, err_timeout} !== 3'b000) begin
            failures++;
            $display("FAIL error_reset: req=%b busy=%b to=%b, want 000", fetch_req, busy, err_timeout);
        end
    endtask

    task automatic test_wrap_reset();
        do_reset(); load_ip(16'hFFFF); begin_run();
        do_instr(0, 1'b1, 2'b01, 16'h0300, 1'b0);
        do_instr(0, 1'b1, 2'b10, 16'h0000, 1'b0);
        do_instr(0, 1'b1, 2'b01, 16'h0310, 1'b0);
        fetch_ack = 1'b1; br_valid = 1'b1; br_type = 2'b01; br_target = 16'h0500;
        tick();
        fetch_ack = 1'b0; br_valid = 1'b0; #1;
        checks++;
        if ({ip_ena, ip_sel, ip_d} !== {2'b11, 16'h0500}) begin
            failures++;
            $display("FAIL redirect_pre_rst: ena=%b sel=%b d=%h, want 1 1 0500", ip_ena, ip_sel, ip_d);
        end
        do_reset(); #1;
        checks++;
        if ({ip_ena, ip_sel, ip_d, fetch_req, fetch_addr, br_ready, busy, stk_ovf, stk_unf, err_timeout} !== 39'b0) begin
            failures++;
            $display("FAIL rst_in_redirect: ena=%b sel=%b d=%h req=%b busy=%b, want all 0",
                     ip_ena, ip_sel, ip_d, fetch_req, busy);
        end
        load_ip(16'h0700); begin_run();
        do_instr(0, 1'b1, 2'b10, 16'h0000, 1'b0);
    endtask

    task automatic test_random();
        do_reset(); load_ip(16'($urandom)); begin_run();
        for (int n = 0; n < 80; n++) begin
            int          dly;
            logic        brv, h;
            logic [1:0]  typ;
            logic [15:0] tgt;
            dly = $urandom_range(0, 14);
            brv = 1'($urandom_range(0, 1));
            typ = 2'($urandom_range(0, 3));
            tgt = 16'($urandom);
            h   = ($urandom_range(0, 7) == 0);
            do_instr(dly, brv, typ, tgt, h);
            if (h) begin_run();
        end
    endtask

    initial begin
        test_reset();
        test_advance_jump();
        test_call_ret();
        test_overflow();
        test_timeout();
        test_wrap_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
